// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates ROB rows at dispatch, marks them complete on FU writeback,
// retires completed rows in program order. Define ROB_DUAL_RETIRE_EN for two retires per cycle.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 7,
  parameter int NUM_FU = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  input  logic [PREG_W-1:0]                 alloc_dst,
  input  logic [PREG_W-1:0]                 alloc_old_dst,
  input  logic                              alloc_reg_write,
  output logic [$clog2(DEPTH)-1:0]          alloc_rob_num,
  input  logic [NUM_FU-1:0]                 cmpl_valid,
  input  logic [NUM_FU*$clog2(DEPTH)-1:0]   cmpl_rob_num,
  output logic [1:0]                        retire_valid,
  output logic [2*PREG_W-1:0]               retire_dst,
  output logic [2*PREG_W-1:0]               retire_old_dst,
  output logic [1:0]                        retire_free,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              empty
);

  localparam int ROB_W = $clog2(DEPTH);
  localparam int CNT_W = ROB_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  complete_q, complete_d;
  logic [DEPTH-1:0]  reg_write_q, reg_write_d;
  logic [PREG_W-1:0] dst_q [DEPTH];
  logic [PREG_W-1:0] dst_d [DEPTH];
  logic [PREG_W-1:0] old_dst_q [DEPTH];
  logic [PREG_W-1:0] old_dst_d [DEPTH];
  logic [ROB_W-1:0]  head_q, head_d;
  logic [ROB_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ROB_W-1:0]  head_p1;
  logic [1:0]        ret;
  logic [1:0]        num_ret;
  logic              accept;
  logic [ROB_W-1:0]  cmpl_idx;

  // Retire slots look only at registered row state, so a same-cycle completion never retires.
  always_comb begin
    head_p1 = head_q + ROB_W'(1);
    ret[0]  = valid_q[head_q] && complete_q[head_q];
`ifdef ROB_DUAL_RETIRE_EN
    ret[1]  = ret[0] && valid_q[head_p1] && complete_q[head_p1];
`else
    ret[1]  = 1'b0;
`endif
    num_ret = {1'b0, ret[0]} + {1'b0, ret[1]};
  end

  // Full blocks allocation even when a retire frees a row this cycle.
  assign alloc_ready   = (count_q < CNT_W'(DEPTH));
  assign accept        = alloc_valid && alloc_ready;
  assign alloc_rob_num = tail_q;
  assign count         = count_q;
  assign empty         = (count_q == '0);

  assign retire_valid     = ret;
  assign retire_free[0]   = ret[0] && reg_write_q[head_q];
  assign retire_free[1]   = ret[1] && reg_write_q[head_p1];
  assign retire_dst       = {ret[1] ? dst_q[head_p1]     : {PREG_W{1'b0}},
                             ret[0] ? dst_q[head_q]      : {PREG_W{1'b0}}};
  assign retire_old_dst   = {ret[1] ? old_dst_q[head_p1] : {PREG_W{1'b0}},
                             ret[0] ? old_dst_q[head_q]  : {PREG_W{1'b0}}};

  always_comb begin
    valid_d     = valid_q;
    complete_d  = complete_q;
    reg_write_d = reg_write_q;
    dst_d       = dst_q;
    old_dst_d   = old_dst_q;
    cmpl_idx    = '0;

    for (int i = 0; i < NUM_FU; i++) begin
      cmpl_idx = cmpl_rob_num[i*ROB_W +: ROB_W];
      if (cmpl_valid[i] && valid_q[cmpl_idx]) begin
        complete_d[cmpl_idx] = 1'b1;
      end
    end

    if (ret[0]) begin
      valid_d[head_q]    = 1'b0;
      complete_d[head_q] = 1'b0;
    end
    if (ret[1]) begin
      valid_d[head_p1]    = 1'b0;
      complete_d[head_p1] = 1'b0;
    end

    // The tail row is never valid when allocation is allowed, so nothing above can collide with it.
    if (accept) begin
      valid_d[tail_q]     = 1'b1;
      complete_d[tail_q]  = 1'b0;
      reg_write_d[tail_q] = alloc_reg_write;
      dst_d[tail_q]       = alloc_dst;
      old_dst_d[tail_q]   = alloc_old_dst;
    end

    head_d  = head_q + ROB_W'(num_ret);
    tail_d  = tail_q + ROB_W'(accept);
    count_d = count_q + CNT_W'(accept) - CNT_W'(num_ret);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      complete_q  <= '0;
      reg_write_q <= '0;
      dst_q       <= '{default: '0};
      old_dst_q   <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      complete_q  <= complete_d;
      reg_write_q <= reg_write_d;
      dst_q       <= dst_d;
      old_dst_q   <= old_dst_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a program-order queue model predicts retirements,
// a monitor pops and compares them whenever the DUT presents a retire slot.
module tb_reorder_buffer;

`ifdef ROB_DUAL_RETIRE_EN
  localparam int MAX_RET = 2;
`else
  localparam int MAX_RET = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [6:0]  alloc_dst = '0;
  logic [6:0]  alloc_old_dst = '0;
  logic        alloc_reg_write = 1'b0;
  logic [3:0]  alloc_rob_num;
  logic [2:0]  cmpl_valid = '0;
  logic [11:0] cmpl_rob_num = '0;
  logic [1:0]  retire_valid;
  logic [13:0] retire_dst;
  logic [13:0] retire_old_dst;
  logic [1:0]  retire_free;
  logic [4:0]  count;
  logic        empty;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_dst       (alloc_dst),
    .alloc_old_dst   (alloc_old_dst),
    .alloc_reg_write (alloc_reg_write),
    .alloc_rob_num   (alloc_rob_num),
    .cmpl_valid      (cmpl_valid),
    .cmpl_rob_num    (cmpl_rob_num),
    .retire_valid    (retire_valid),
    .retire_dst      (retire_dst),
    .retire_old_dst  (retire_old_dst),
    .retire_free     (retire_free),
    .count           (count),
    .empty           (empty)
  );

  typedef struct {int rob; int dst; int old; bit rw; bit done;} ent_t;
  typedef struct {int dst; int old; bit free;} ret_t;

  ent_t mq[$];     // in-flight instructions, oldest first
  ret_t exp_q[$];  // expected retirements, in order
  int   mtail = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Called mid-cycle; asserts reset before the next rising edge and checks outputs immediately.
  task automatic do_reset();
    #4;
    reset_n     = 1'b0;
    alloc_valid = 1'b0;
    cmpl_valid  = '0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_retire_valid", int'(retire_valid), 0);
    chk("rst_retire_free", int'(retire_free), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_alloc_ready", int'(alloc_ready), 1);
    chk("rst_alloc_rob_num", int'(alloc_rob_num), 0);
    chk("rst_retire_data", int'(retire_dst | retire_old_dst), 0);
    mq.delete();
    exp_q.delete();
    mtail = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input bit av, input int d, input int o, input bit rw,
                      input bit [2:0] cv, input bit [11:0] cn);
    int     nret;
    int     sz0;
    bit [1:0] erv;
    ret_t   r;
    ent_t   e;
    @(negedge clk);
    chk("count", int'(count), mq.size());
    chk("alloc_ready", int'(alloc_ready), int'(mq.size() < 16));
    chk("alloc_rob_num", int'(alloc_rob_num), mtail);
    chk("empty", int'(empty), int'(mq.size() == 0));
    nret = 0;
    erv  = '0;
    while (nret < MAX_RET && nret < mq.size() && mq[nret].done) begin
      r.dst  = mq[nret].dst;
      r.old  = mq[nret].old;
      r.free = mq[nret].rw;
      exp_q.push_back(r);
      erv[nret] = 1'b1;
      nret++;
    end
    chk("retire_valid", int'(retire_valid), int'(erv));

    alloc_valid     = av;
    alloc_dst       = 7'(d);
    alloc_old_dst   = 7'(o);
    alloc_reg_write = rw;
    cmpl_valid      = cv;
    cmpl_rob_num    = cn;

    sz0 = mq.size();
    repeat (nret) void'(mq.pop_front());
    for (int i = 0; i < 3; i++) begin
      if (cv[i]) begin
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j].rob == int'(cn[4*i +: 4])) begin
            e = mq[j];
            e.done = 1'b1;
            mq[j] = e;
          end
        end
      end
    end
    if (av && sz0 < 16) begin
      e.rob = mtail; e.dst = d & 127; e.old = o & 127; e.rw = rw; e.done = 1'b0;
      mq.push_back(e);
      mtail = (mtail + 1) % 16;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0, 3'b000, 12'd0);
  endtask

  function automatic int pick_rob();
    if (mq.size() > 0 && $urandom_range(9) < 7) return mq[$urandom_range(mq.size() - 1)].rob;
    return int'($urandom_range(15));
  endfunction

  // Retire monitor
  initial begin
    ret_t r;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        for (int k = 0; k < 2; k++) begin
          if (retire_valid[k]) begin
            if (exp_q.size() == 0) begin
              chk("retire_unexpected", 1, 0);
            end else begin
              r = exp_q.pop_front();
              chk("retire_dst", int'(retire_dst[k*7 +: 7]), r.dst);
              chk("retire_old_dst", int'(retire_old_dst[k*7 +: 7]), r.old);
              chk("retire_free", int'(retire_free[k]), int'(r.free));
            end
          end else begin
            chk("idle_slot_zero",
                int'({retire_dst[k*7 +: 7], retire_old_dst[k*7 +: 7], retire_free[k]}), 0);
          end
        end
      end
    end
  end

  initial begin
    int r;
    bit [2:0]  cv;
    bit [11:0] cn;

    do_reset();

    // allocate three rows, complete out of order
    step(1'b1, 32, 1, 1'b1, 3'b000, 12'd0);
    step(1'b1, 33, 2, 1'b1, 3'b000, 12'd0);
    step(1'b1, 34, 3, 1'b1, 3'b000, 12'd0);
    step(1'b0, 0, 0, 1'b0, 3'b001, 12'd2);
    step(1'b0, 0, 0, 1'b0, 3'b001, 12'd1);
    step(1'b0, 0, 0, 1'b0, 3'b001, 12'd0);
    idle(4);

    // fill, retire while full, then allocate after wrap
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 40 + i, i, 1'b1, 3'b000, 12'd0);
    step(1'b1, 60, 20, 1'b1, 3'b001, 12'd0);
    step(1'b1, 61, 21, 1'b1, 3'b000, 12'd0);
    step(1'b1, 62, 22, 1'b1, 3'b000, 12'd0);
    for (int j = 0; j < 16; j += 3)
      step(1'b0, 0, 0, 1'b0, 3'b111, {4'(j + 2), 4'(j + 1), 4'(j)});
    idle(12);

    // RegWrite = 0 row
    r = mtail;
    step(1'b1, 70, 9, 1'b0, 3'b000, 12'd0);
    step(1'b0, 0, 0, 1'b0, 3'b010, {4'd0, 4'(r), 4'd0});
    idle(3);

    // three-port completion, plus a completion to an unallocated row
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 80 + i, 50 + i, 1'(i % 2), 3'b000, 12'd0);
    step(1'b0, 0, 0, 1'b0, 3'b111, {4'd6, 4'd5, 4'd4});
    step(1'b0, 0, 0, 1'b0, 3'b001, 12'd9);
    step(1'b0, 0, 0, 1'b0, 3'b111, {4'd2, 4'd1, 4'd0});
    step(1'b0, 0, 0, 1'b0, 3'b001, 12'd3);
    idle(6);

    // reset mid-operation with a retire pending
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 90 + i, 60 + i, 1'b1, 3'b000, 12'd0);
    step(1'b0, 0, 0, 1'b0, 3'b001, 12'd0);
    step(1'b0, 0, 0, 1'b0, 3'b000, 12'd0);
    do_reset();
    idle(2);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      cv = '0;
      cn = '0;
      for (int i = 0; i < 3; i++) begin
        cv[i] = ($urandom_range(2) == 0);
        cn[4*i +: 4] = 4'(pick_rob());
      end
      step(1'($urandom_range(9) < 6), int'($urandom_range(127)), int'($urandom_range(127)),
           1'($urandom_range(1)), cv, cn);
    end
    for (int j = 0; j < 16; j += 3)
      step(1'b0, 0, 0, 1'b0, 3'b111, {4'(j + 2), 4'(j + 1), 4'(j)});
    idle(20);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order core. Sits between rename/dispatch and the physical-register free list. Accepts one renamed instruction per cycle and hands back its ROB number for the reservation-station row. Marks entries complete on functional-unit writeback, then retires completed entries strictly in program order, releasing each retired instruction's `OldPRegAddrDst` to the free list.

## Interface
- `DEPTH`, 16: number of rows; power of two; ROB number width is log2(`DEPTH`) = 4.
- `PREG_W`, 7: physical register address width (`p_reg`).
- `NUM_FU`, 3: completion ports, one per functional unit (FU1, FU2, FU3/mem).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alloc_valid`  in  1  dispatch presents an instruction.
- `alloc_ready`  out  1  a row is free; `alloc_valid && alloc_ready` means the instruction is accepted.
- `alloc_dst`  in  `PREG_W`  `PRegAddrDst` of the dispatched instruction.
- `alloc_old_dst`  in  `PREG_W`  `OldPRegAddrDst` of the dispatched instruction.
- `alloc_reg_write`  in  1  `RegWrite` of the dispatched instruction.
- `alloc_rob_num`  out  4  tail index; the ROB number given to the accepted instruction.
- `cmpl_valid`  in  `NUM_FU`  per-FU completion strobe.
- `cmpl_rob_num`  in  `NUM_FU`*4  packed ROB numbers; FU i uses bits [4i+3:4i].
- `retire_valid`  out  2  slot k retires this cycle.
- `retire_dst`  out  2*`PREG_W`  packed `PRegAddrDst` per retire slot.
- `retire_old_dst`  out  2*`PREG_W`  packed `OldPRegAddrDst` per retire slot.
- `retire_free`  out  2  `retire_valid[k] && reg_write[k]`; the free list releases `retire_old_dst[k]`.
- `count`  out  5  occupied rows, 0..16.
- `empty`  out  1  `count == 0`.

## Operation
- Each row stores `rob_row_struct` fields (`valid`, `PRegAddrDst`, `OldPRegAddrDst`, `complete`) plus `reg_write`.
- Pointers are 4-bit `head` and `tail` that wrap 15→0. `count` is a 5-bit register.
- **Allocate:**
  - `alloc_ready = (count < DEPTH)`, driven from registered `count`. It does not bypass same-cycle retirement.
  - On accept, at the clock edge: `row[tail]` gets `valid=1`, `complete=0`, and the payload; `tail` increments.
- **Complete:**
  - For each i with `cmpl_valid[i]` set, `row[cmpl_rob_num[i]].complete` is set to 1 at the clock edge, but only if that row is valid. A completion to an invalid row is ignored.
  - Several ports may complete different rows in the same cycle.
  - Duplicate ROB numbers across ports are harmless; the row is simply set complete.
- **Retire:**
  - Slot 0 is `valid[head] && complete[head]`.
  - Slot 1 is slot 0 AND `valid[head+1] && complete[head+1]`.
  - Both slots are combinational from registered row state.
  - Retired rows are cleared (`valid=0`, `complete=0`) at the edge, and `head` advances by the number retired.
- **Count:** `count_next = count + accepted - retired`. Allocate and retire in the same cycle are both honoured.
- A completion and a retire cannot target the same row in the same cycle, because retire requires `complete` to already be registered.

## Timing
- **Reset:** while `reset_n` is low, asynchronously:
  - all rows cleared; `head = tail = 0`; `count = 0`.
  - outputs: `alloc_ready = 1`, `alloc_rob_num = 0`, `retire_valid = 0`, `retire_free = 0`, `retire_dst = retire_old_dst = 0`, `empty = 1`.
- Reset asserted mid-operation discards all in-flight rows. There is no drain.
- **Allocate latency:** an instruction accepted at edge N is visible in row state after edge N.
- **Completion latency:** a completion strobed in the cycle ending at edge M sets `complete` at edge M. The earliest retire is the cycle after M, and the row is freed at edge M+1.
- **Full (`count == 16`):** `alloc_ready = 0`, even if a retire occurs in the same cycle. The freed row becomes allocatable one cycle later.
- **Empty:** `retire_valid = 0`, regardless of completion strobes.

## Configuration
- `ROB_DUAL_RETIRE_EN` defined: up to two retires per cycle, as described above.
- Not defined:
  - slot 1 is tied off: `retire_valid[1] = 0`, `retire_free[1] = 0`, and its data is 0.
  - `head` advances by at most 1 per cycle.
  - port widths are unchanged.

## Test plan
- **Reset, then allocate 3 rows:** allocate (dst, old) = (32,1), (33,2), (34,3). `alloc_rob_num` reads 0, 1, 2; `count = 3`; no retire.
- **Out-of-order completion:** complete ROB 2, then ROB 1 → no retire. Then complete ROB 0 → next cycle `retire_valid = 2'b11` with old_dst 1, 2; the cycle after that, old_dst 3 retires. With the macro undefined, old_dst 1, 2, 3 retire on three consecutive cycles.
- **Fill and wrap-around:** allocate 16 rows → `alloc_ready = 0`, `count = 16`. Complete and retire the head while `alloc_valid = 1` → no accept that cycle; accept the next cycle with `alloc_rob_num = 0` after the wrap.
- **`RegWrite = 0` row:** completed and retired → `retire_valid = 1`, `retire_free = 0`.
- **Simultaneous 3-port completion:** complete rows 4, 5, 6 in one cycle → all marked complete. A completion to an unallocated row 9 → no state change.
- **Reset mid-operation:** assert `reset_n = 0` with 5 rows valid → `count = 0`, `retire_valid = 0` immediately, before the next clock edge.
